// File: rtl/fractal_pkg.sv
// Shared types and helpers for the escape-time fractal pixel generator:
// colouring mode, engine state, pixel tags and the escape threshold.
package fractal_pkg;

    typedef enum logic {
        MODE_MANDEL = 1'b0,
        MODE_JULIA  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_ITER = 2'd1,
        ENG_DONE = 2'd2
    } eng_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
    } pix_tag_t;

    localparam int THRESH_W = 64;

    // |z|^2 bound of 4.0 expressed in the fixed-point scale
    function automatic logic [THRESH_W-1:0] escape_threshold(input int frac_bits);
        escape_threshold = 64'd4 << frac_bits;
    endfunction

endpackage

// File: rtl/fractal_engine.sv
// One escape-time iteration engine: loads z0/c on start, iterates until escape
// or the limit, then holds its count until the collector takes it.
module fractal_engine
    import fractal_pkg::*;
#(
    parameter int COORD_W   = 32,
    parameter int FRAC_BITS = 8,
    parameter int ITER_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [COORD_W-1:0] z0_re_i,
    input  logic [COORD_W-1:0] z0_im_i,
    input  logic [COORD_W-1:0] c_re_i,
    input  logic [COORD_W-1:0] c_im_i,
    input  logic [ITER_W-1:0]  max_iter_i,
    input  logic               sof_i,
    input  logic               eol_i,
    input  logic               collect_i,
    output logic [1:0]         state_o,
    output logic [ITER_W-1:0]  result_o,
    output logic               sof_o,
    output logic               eol_o
);

    localparam int PW = 2 * COORD_W;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] THRESH = SW'(escape_threshold(FRAC_BITS));
    localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    eng_state_e                 state_q, state_d;
    logic signed [COORD_W-1:0]  zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic [ITER_W-1:0]          k_q, k_d, max_q, max_d;
    pix_tag_t                   tag_q, tag_d;

    logic signed [PW-1:0]       zr_w_s, zi_w_s, cr_w_s;
    logic signed [PW-1:0]       sq_re_s, sq_im_s;
    logic signed [SW-1:0]       mag_s, cross_s, ci_x_s;
    logic signed [COORD_W-1:0]  zr_next_s, zi_next_s;
    logic                       escape_s;

    assign zr_w_s = {{COORD_W{zr_q[COORD_W-1]}}, zr_q};
    assign zi_w_s = {{COORD_W{zi_q[COORD_W-1]}}, zi_q};
    assign cr_w_s = {{COORD_W{cr_q[COORD_W-1]}}, cr_q};
    assign ci_x_s = {{(COORD_W+1){ci_q[COORD_W-1]}}, ci_q};

    assign sq_re_s  = (zr_w_s * zr_w_s) >>> FRAC_BITS;
    assign sq_im_s  = (zi_w_s * zi_w_s) >>> FRAC_BITS;
    // one extra bit so the magnitude sum can never wrap below the threshold
    assign mag_s    = {sq_re_s[PW-1], sq_re_s} + {sq_im_s[PW-1], sq_im_s};
    assign escape_s = (mag_s > THRESH);

    assign cross_s   = {zr_w_s * zi_w_s, 1'b0};
    assign zr_next_s = COORD_W'(sq_re_s - sq_im_s + cr_w_s);
    assign zi_next_s = COORD_W'((cross_s >>> FRAC_BITS) + ci_x_s);

    assign state_o  = state_q;
    assign result_o = k_q;
    assign sof_o    = tag_q.sof;
    assign eol_o    = tag_q.eol;

    // Engine state machine and iteration datapath next-state
    always_comb begin
        state_d = state_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        k_d     = k_q;
        max_d   = max_q;
        tag_d   = tag_q;
        case (state_q)
            ENG_IDLE: begin
                if (start_i) begin
                    state_d = ENG_ITER;
                    zr_d    = z0_re_i;
                    zi_d    = z0_im_i;
                    cr_d    = c_re_i;
                    ci_d    = c_im_i;
                    k_d     = {ITER_W{1'b0}};
                    max_d   = max_iter_i;
                    tag_d   = '{sof: sof_i, eol: eol_i};
                end else begin
                    state_d = ENG_IDLE;
                end
            end
            ENG_ITER: begin
                if (escape_s || (k_q == max_q)) begin
                    state_d = ENG_DONE;
                end else begin
                    k_d  = k_q + ITER_ONE;
                    zr_d = zr_next_s;
                    zi_d = zi_next_s;
                end
            end
            ENG_DONE: begin
                // a collect frees the engine; a dispatch in that same cycle reloads it
                if (collect_i && start_i) begin
                    state_d = ENG_ITER;
                    zr_d    = z0_re_i;
                    zi_d    = z0_im_i;
                    cr_d    = c_re_i;
                    ci_d    = c_im_i;
                    k_d     = {ITER_W{1'b0}};
                    max_d   = max_iter_i;
                    tag_d   = '{sof: sof_i, eol: eol_i};
                end else if (collect_i) begin
                    state_d = ENG_IDLE;
                end else begin
                    state_d = ENG_DONE;
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

    // Engine registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ENG_IDLE;
            zr_q    <= {COORD_W{1'b0}};
            zi_q    <= {COORD_W{1'b0}};
            cr_q    <= {COORD_W{1'b0}};
            ci_q    <= {COORD_W{1'b0}};
            k_q     <= {ITER_W{1'b0}};
            max_q   <= {ITER_W{1'b0}};
            tag_q   <= '{sof: 1'b0, eol: 1'b0};
        end else begin
            state_q <= state_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            k_q     <= k_d;
            max_q   <= max_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: rtl/fractal_pixel_array.sv
// Raster-order fractal pixel generator: sweeps the frame, deals pixels round-robin
// to parallel engines and collects the counts back in the same order.
module fractal_pixel_array
    import fractal_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int COORD_W     = 32,
    parameter int FRAC_BITS   = 8,
    parameter int ITER_W      = 8,
    parameter int DIM_W       = 12
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               enable,
    input  logic               cfg_mode,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    input  logic [ITER_W-1:0]  cfg_max_iter,
    input  logic [COORD_W-1:0] cfg_origin_re,
    input  logic [COORD_W-1:0] cfg_origin_im,
    input  logic [COORD_W-1:0] cfg_step_re,
    input  logic [COORD_W-1:0] cfg_step_im,
    input  logic [COORD_W-1:0] cfg_julia_re,
    input  logic [COORD_W-1:0] cfg_julia_im,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ITER_W-1:0]  m_iter,
    output logic               m_sof,
    output logic               m_eol,
    output logic               busy
);

    localparam int RR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [RR_W-1:0]  RR_LAST = RR_W'(NUM_ENGINES - 1);
    localparam logic [RR_W-1:0]  RR_ONE  = {{(RR_W-1){1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0] DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

    // dispatcher state
    logic [DIM_W-1:0]   x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] p_re_q, p_re_d, p_im_q, p_im_d;
    logic [RR_W-1:0]    rr_in_q, rr_in_d, rr_out_q, rr_out_d;

    // per-frame configuration snapshot
    mode_e              snap_mode_q;
    logic [DIM_W-1:0]   snap_width_q, snap_height_q;
    logic [ITER_W-1:0]  snap_max_q;
    logic [COORD_W-1:0] snap_org_re_q, snap_org_im_q, snap_step_re_q, snap_step_im_q;
    logic [COORD_W-1:0] snap_jul_re_q, snap_jul_im_q;

    // output register
    logic               valid_q, valid_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    pix_tag_t           out_tag_q, out_tag_d;

    logic               frame_start_s, line_end_s, dispatch_s, collect_s, busy_s;
    mode_e              eff_mode_s;
    logic [DIM_W-1:0]   eff_width_s, eff_height_s;
    logic [ITER_W-1:0]  eff_max_s;
    logic [COORD_W-1:0] eff_org_re_s, eff_org_im_s, eff_step_re_s, eff_step_im_s;
    logic [COORD_W-1:0] eff_jul_re_s, eff_jul_im_s;
    logic [COORD_W-1:0] cur_re_s, cur_im_s;
    logic [COORD_W-1:0] disp_z0_re_s, disp_z0_im_s, disp_c_re_s, disp_c_im_s;
    pix_tag_t           disp_tag_s;

    logic [NUM_ENGINES-1:0] eng_start_s, eng_collect_s;
    logic [1:0]             eng_state_s  [NUM_ENGINES];
    logic [ITER_W-1:0]      eng_result_s [NUM_ENGINES];
    logic                   eng_sof_s    [NUM_ENGINES];
    logic                   eng_eol_s    [NUM_ENGINES];

    // Pixel (0,0) must already see the live config being snapshotted in its cycle
    assign frame_start_s = (x_q == {DIM_W{1'b0}}) && (y_q == {DIM_W{1'b0}});
    assign eff_mode_s    = frame_start_s ? mode_e'(cfg_mode) : snap_mode_q;
    assign eff_width_s   = frame_start_s ? cfg_width         : snap_width_q;
    assign eff_height_s  = frame_start_s ? cfg_height        : snap_height_q;
    assign eff_max_s     = frame_start_s ? cfg_max_iter      : snap_max_q;
    assign eff_org_re_s  = frame_start_s ? cfg_origin_re     : snap_org_re_q;
    assign eff_org_im_s  = frame_start_s ? cfg_origin_im     : snap_org_im_q;
    assign eff_step_re_s = frame_start_s ? cfg_step_re       : snap_step_re_q;
    assign eff_step_im_s = frame_start_s ? cfg_step_im       : snap_step_im_q;
    assign eff_jul_re_s  = frame_start_s ? cfg_julia_re      : snap_jul_re_q;
    assign eff_jul_im_s  = frame_start_s ? cfg_julia_im      : snap_jul_im_q;
    assign cur_re_s      = frame_start_s ? cfg_origin_re     : p_re_q;
    assign cur_im_s      = frame_start_s ? cfg_origin_im     : p_im_q;

    assign line_end_s   = (x_q == (eff_width_s - DIM_ONE));
    assign disp_tag_s   = '{sof: frame_start_s, eol: line_end_s};
    assign disp_z0_re_s = (eff_mode_s == MODE_JULIA) ? cur_re_s : {COORD_W{1'b0}};
    assign disp_z0_im_s = (eff_mode_s == MODE_JULIA) ? cur_im_s : {COORD_W{1'b0}};
    assign disp_c_re_s  = (eff_mode_s == MODE_JULIA) ? eff_jul_re_s : cur_re_s;
    assign disp_c_im_s  = (eff_mode_s == MODE_JULIA) ? eff_jul_im_s : cur_im_s;

    assign collect_s  = (!valid_q || m_ready) && (eng_state_s[rr_out_q] == ENG_DONE);
    assign dispatch_s = enable && ((eng_state_s[rr_in_q] == ENG_IDLE) || eng_collect_s[rr_in_q]);

    // Per-engine start and collect strobes plus the busy summary
    always_comb begin
        eng_start_s   = {NUM_ENGINES{1'b0}};
        eng_collect_s = {NUM_ENGINES{1'b0}};
        busy_s        = valid_q;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            eng_start_s[i]   = dispatch_s && (rr_in_q == RR_W'(i));
            eng_collect_s[i] = collect_s && (rr_out_q == RR_W'(i));
            busy_s           = busy_s | (eng_state_s[i] != ENG_IDLE);
        end
    end

    // Raster walk with incremental coordinates
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        p_re_d  = p_re_q;
        p_im_d  = p_im_q;
        rr_in_d = rr_in_q;
        if (dispatch_s) begin
            rr_in_d = (rr_in_q == RR_LAST) ? {RR_W{1'b0}} : rr_in_q + RR_ONE;
            if (line_end_s) begin
                x_d    = {DIM_W{1'b0}};
                p_re_d = eff_org_re_s;
                if (y_q == (eff_height_s - DIM_ONE)) begin
                    y_d    = {DIM_W{1'b0}};
                    p_im_d = eff_org_im_s;
                end else begin
                    y_d    = y_q + DIM_ONE;
                    p_im_d = cur_im_s + eff_step_im_s;
                end
            end else begin
                x_d    = x_q + DIM_ONE;
                p_re_d = cur_re_s + eff_step_re_s;
                p_im_d = cur_im_s;
            end
        end else begin
            rr_in_d = rr_in_q;
        end
    end

    // Output register: reload on a collect, otherwise drop valid after a transfer
    always_comb begin
        valid_d   = valid_q;
        iter_d    = iter_q;
        out_tag_d = out_tag_q;
        rr_out_d  = rr_out_q;
        if (collect_s) begin
            valid_d   = 1'b1;
            iter_d    = eng_result_s[rr_out_q];
            out_tag_d = '{sof: eng_sof_s[rr_out_q], eol: eng_eol_s[rr_out_q]};
            rr_out_d  = (rr_out_q == RR_LAST) ? {RR_W{1'b0}} : rr_out_q + RR_ONE;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Dispatcher, snapshot and output registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            x_q            <= {DIM_W{1'b0}};
            y_q            <= {DIM_W{1'b0}};
            p_re_q         <= {COORD_W{1'b0}};
            p_im_q         <= {COORD_W{1'b0}};
            rr_in_q        <= {RR_W{1'b0}};
            rr_out_q       <= {RR_W{1'b0}};
            snap_mode_q    <= MODE_MANDEL;
            snap_width_q   <= {DIM_W{1'b0}};
            snap_height_q  <= {DIM_W{1'b0}};
            snap_max_q     <= {ITER_W{1'b0}};
            snap_org_re_q  <= {COORD_W{1'b0}};
            snap_org_im_q  <= {COORD_W{1'b0}};
            snap_step_re_q <= {COORD_W{1'b0}};
            snap_step_im_q <= {COORD_W{1'b0}};
            snap_jul_re_q  <= {COORD_W{1'b0}};
            snap_jul_im_q  <= {COORD_W{1'b0}};
            valid_q        <= 1'b0;
            iter_q         <= {ITER_W{1'b0}};
            out_tag_q      <= '{sof: 1'b0, eol: 1'b0};
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            p_re_q   <= p_re_d;
            p_im_q   <= p_im_d;
            rr_in_q  <= rr_in_d;
            rr_out_q <= rr_out_d;
            if (dispatch_s && frame_start_s) begin
                snap_mode_q    <= eff_mode_s;
                snap_width_q   <= cfg_width;
                snap_height_q  <= cfg_height;
                snap_max_q     <= cfg_max_iter;
                snap_org_re_q  <= cfg_origin_re;
                snap_org_im_q  <= cfg_origin_im;
                snap_step_re_q <= cfg_step_re;
                snap_step_im_q <= cfg_step_im;
                snap_jul_re_q  <= cfg_julia_re;
                snap_jul_im_q  <= cfg_julia_im;
            end
            valid_q   <= valid_d;
            iter_q    <= iter_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign m_valid = valid_q;
    assign m_iter  = iter_q;
    assign m_sof   = out_tag_q.sof;
    assign m_eol   = out_tag_q.eol;
    assign busy    = busy_s;

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
        fractal_engine #(
            .COORD_W   (COORD_W),
            .FRAC_BITS (FRAC_BITS),
            .ITER_W    (ITER_W)
        ) u_engine (
            .clk_i      (aclk),
            .rst_i      (areset),
            .start_i    (eng_start_s[g]),
            .z0_re_i    (disp_z0_re_s),
            .z0_im_i    (disp_z0_im_s),
            .c_re_i     (disp_c_re_s),
            .c_im_i     (disp_c_im_s),
            .max_iter_i (eff_max_s),
            .sof_i      (disp_tag_s.sof),
            .eol_i      (disp_tag_s.eol),
            .collect_i  (eng_collect_s[g]),
            .state_o    (eng_state_s[g]),
            .result_o   (eng_result_s[g]),
            .sof_o      (eng_sof_s[g]),
            .eol_o      (eng_eol_s[g])
        );
    end

endmodule

// File: tb/tb_fractal_pixel_array.sv
// Self-checking bench for fractal_pixel_array: directed escape cases, randomized
// raster streams under backpressure, mid-frame config change and mid-frame reset.
module tb_fractal_pixel_array;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_mode = 1'b0;
    logic [11:0] cfg_width = 12'd1;
    logic [11:0] cfg_height = 12'd1;
    logic [7:0]  cfg_max_iter = 8'd1;
    logic [31:0] cfg_origin_re = 32'd0;
    logic [31:0] cfg_origin_im = 32'd0;
    logic [31:0] cfg_step_re = 32'd0;
    logic [31:0] cfg_step_im = 32'd0;
    logic [31:0] cfg_julia_re = 32'd0;
    logic [31:0] cfg_julia_im = 32'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_iter;
    logic        m_sof;
    logic        m_eol;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fractal_pixel_array #(
        .NUM_ENGINES(4), .COORD_W(32), .FRAC_BITS(8), .ITER_W(8), .DIM_W(12)
    ) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .cfg_mode(cfg_mode),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_max_iter(cfg_max_iter),
        .cfg_origin_re(cfg_origin_re), .cfg_origin_im(cfg_origin_im),
        .cfg_step_re(cfg_step_re), .cfg_step_im(cfg_step_im),
        .cfg_julia_re(cfg_julia_re), .cfg_julia_im(cfg_julia_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_iter(m_iter),
        .m_sof(m_sof), .m_eol(m_eol), .busy(busy)
    );

    always #5 aclk = ~aclk;

    // Escape-time count straight from the mathematical definition (scale 256).
    function automatic int ref_iter(input bit jul, input int pre, input int pim,
                                    input int jre, input int jim, input int maxi);
        longint zr, zi, cr, ci, sr, si, nzr;
        int t;
        if (jul) begin zr = pre; zi = pim; cr = jre; ci = jim; end
        else     begin zr = 0;   zi = 0;   cr = pre; ci = pim; end
        for (int k = 0; k < maxi; k++) begin
            sr = (zr * zr) >>> 8;
            si = (zi * zi) >>> 8;
            if (sr + si > 64'sd1024) return k;
            t = int'(sr - si + cr);
            nzr = t;
            t = int'(((2 * zr * zi) >>> 8) + ci);
            zi = t;
            zr = nzr;
        end
        return maxi;
    endfunction

    task automatic apply_reset();
        enable = 1'b0;
        m_ready = 1'b1;
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic set_cfg(input bit mode, input int w, input int h, input int maxi,
                           input int ore, input int oim, input int sre, input int sim,
                           input int jre, input int jim);
        cfg_mode = mode;
        cfg_width = 12'(w);
        cfg_height = 12'(h);
        cfg_max_iter = 8'(maxi);
        cfg_origin_re = ore;
        cfg_origin_im = oim;
        cfg_step_re = sre;
        cfg_step_im = sim;
        cfg_julia_re = jre;
        cfg_julia_im = jim;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_iter !== 8'd0) begin errors++; $display("FAIL reset_iter got=%0d exp=0", m_iter); end
        checks++; if (m_sof !== 1'b0) begin errors++; $display("FAIL reset_sof got=%b exp=0", m_sof); end
        checks++; if (m_eol !== 1'b0) begin errors++; $display("FAIL reset_eol got=%b exp=0", m_eol); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    // One pixel in a 1x1 frame; checks count, flags and dispatch-to-valid latency.
    task automatic test_single(input string name, input bit mode, input int ore, input int oim,
                               input int jre, input int jim, input int maxi, input int exp_iter);
        int lat;
        apply_reset();
        set_cfg(mode, 1, 1, maxi, ore, oim, 0, 0, jre, jim);
        @(negedge aclk);
        enable = 1'b1;
        @(posedge aclk);
        #1 enable = 1'b0;
        lat = 0;
        while (!m_valid && lat < 600) begin
            @(posedge aclk);
            #1 lat++;
        end
        checks++; if (m_iter !== 8'(exp_iter)) begin errors++; $display("FAIL %s_iter got=%0d exp=%0d", name, m_iter, exp_iter); end
        checks++; if (m_sof !== 1'b1) begin errors++; $display("FAIL %s_sof got=%b exp=1", name, m_sof); end
        checks++; if (m_eol !== 1'b1) begin errors++; $display("FAIL %s_eol got=%b exp=1", name, m_eol); end
        checks++; if (lat != exp_iter + 2) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_iter + 2); end
    endtask

    // Two back-to-back 8x4 frames under random backpressure; optionally rewrites
    // mode/origin_re early in frame 1, which must only affect frame 2.
    task automatic test_raster_stream(input string name, input bit change);
        int exp_iter[64];
        bit exp_sof[64], exp_eol[64];
        int maxi, ore, ore_b, oim, sre, sim, jre, jim;
        int j, px, py, got, cycles;
        bit useb, held, changed;
        logic [7:0] h_iter;
        logic h_sof, h_eol;
        maxi = $urandom_range(12, 40);
        ore = -560 + $urandom_range(0, 64);
        ore_b = -384 + $urandom_range(0, 32);
        oim = -300 + $urandom_range(0, 40);
        sre = 90 + $urandom_range(0, 16);
        sim = 140 + $urandom_range(0, 16);
        jre = -205;
        jim = 40;
        for (int i = 0; i < 64; i++) begin
            j = i % 32;
            px = j % 8;
            py = j / 8;
            useb = change && (i >= 32);
            exp_iter[i] = ref_iter(useb, (useb ? ore_b : ore) + px * sre, oim + py * sim, jre, jim, maxi);
            exp_sof[i] = (j == 0);
            exp_eol[i] = (px == 7);
        end
        apply_reset();
        set_cfg(1'b0, 8, 4, maxi, ore, oim, sre, sim, jre, jim);
        got = 0; cycles = 0; held = 1'b0; changed = 1'b0;
        h_iter = 8'd0; h_sof = 1'b0; h_eol = 1'b0;
        enable = 1'b1;
        while (got < 64 && cycles < 20000) begin
            @(negedge aclk);
            cycles++;
            if (held) begin
                checks++;
                if (m_valid !== 1'b1 || m_iter !== h_iter || m_sof !== h_sof || m_eol !== h_eol) begin
                    errors++;
                    $display("FAIL %s_stall_hold got=%b/%0d/%b/%b exp=1/%0d/%b/%b", name,
                             m_valid, m_iter, m_sof, m_eol, h_iter, h_sof, h_eol);
                end
            end
            if (change && !changed && got == 10) begin
                cfg_mode = 1'b1;
                cfg_origin_re = ore_b;
                changed = 1'b1;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            held = 1'b0;
            if (m_valid === 1'b1) begin
                if (m_ready) begin
                    checks++; if (m_iter !== 8'(exp_iter[got])) begin errors++; $display("FAIL %s_iter[%0d] got=%0d exp=%0d", name, got, m_iter, exp_iter[got]); end
                    checks++; if (m_sof !== exp_sof[got]) begin errors++; $display("FAIL %s_sof[%0d] got=%b exp=%b", name, got, m_sof, exp_sof[got]); end
                    checks++; if (m_eol !== exp_eol[got]) begin errors++; $display("FAIL %s_eol[%0d] got=%b exp=%b", name, got, m_eol, exp_eol[got]); end
                    got++;
                end else begin
                    held = 1'b1;
                    h_iter = m_iter; h_sof = m_sof; h_eol = m_eol;
                end
            end
        end
        checks++; if (got != 64) begin errors++; $display("FAIL %s_count got=%0d exp=64", name, got); end
        enable = 1'b0;
        m_ready = 1'b1;
    endtask

    // Reset pulse with three engines iterating, then a fresh frame must start at (0,0).
    task automatic test_midframe_reset();
        int lat, exp0;
        apply_reset();
        set_cfg(1'b0, 8, 4, 200, 0, 0, 1, 1, 0, 0);
        @(negedge aclk);
        enable = 1'b1;
        repeat (3) @(negedge aclk);
        enable = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mreset_busy_before got=%b exp=1", busy); end
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mreset_valid got=%b exp=0", m_valid); end
        checks++; if (m_iter !== 8'd0) begin errors++; $display("FAIL mreset_iter got=%0d exp=0", m_iter); end
        checks++; if (m_sof !== 1'b0) begin errors++; $display("FAIL mreset_sof got=%b exp=0", m_sof); end
        checks++; if (m_eol !== 1'b0) begin errors++; $display("FAIL mreset_eol got=%b exp=0", m_eol); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mreset_busy got=%b exp=0", busy); end
        set_cfg(1'b0, 8, 4, 20, -300, 100, 60, 60, 0, 0);
        exp0 = ref_iter(1'b0, -300, 100, 0, 0, 20);
        enable = 1'b1;
        lat = 0;
        while (!m_valid && lat < 600) begin
            @(negedge aclk);
            lat++;
        end
        enable = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mreset_timeout got=%b exp=1", m_valid); end
        checks++; if (m_sof !== 1'b1) begin errors++; $display("FAIL mreset_first_sof got=%b exp=1", m_sof); end
        checks++; if (m_iter !== 8'(exp0)) begin errors++; $display("FAIL mreset_first_iter got=%0d exp=%0d", m_iter, exp0); end
    endtask

    initial begin
        test_reset();
        test_single("mandel_origin", 1'b0, 0, 0, 0, 0, 50, 50);
        test_single("mandel_c2", 1'b0, 512, 0, 0, 0, 50, 2);
        test_single("mandel_cm2", 1'b0, -512, 0, 0, 0, 30, 30);
        test_single("julia_z3", 1'b1, 768, 0, 0, 0, 30, 0);
        test_raster_stream("raster", 1'b0);
        test_raster_stream("cfgchg", 1'b1);
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
